vga_fifo_fetch: RTL and testbench
=================================

Name: vga_fifo_fetch

Overview:
- Upstream feeder for the 640x480 VGA/HDMI pixel stage, running in the CPU clock domain.
- Fetches 32-bit pixel words from RAM through a simple req/ack read port and buffers them in a small FIFO.
- Presents the FIFO head as red/green/blue/bright bytes, with one word covering 8 pixels, one bit per pixel per plane.
- Advances to the next word on each one-clock rd pulse from the display stage; the display vsync flushes the FIFO and restarts at the frame base address.

Parameters:
- addr_width, 30, width of the word address to RAM.
- fifo_depth_log2, 4, log2 of the FIFO depth (16 words).
- words_per_frame, 38400, words fetched per frame (640*480/8).

Ports:
- clk  in  1  CPU clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- base_addr  in  addr_width  frame base word address; sampled at each flush.
- fetch_enable  in  1  when 0, no new memory requests are issued.
- mem_addr  out  addr_width  RAM word address.
- mem_req  out  1  read request; held until mem_ack.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  32  RAM read data.
- rd  in  1  one-clk pulse from the display stage: current word consumed, pop.
- vsync_n  in  1  display vsync, active low, pixclk domain (asynchronous to clk).
- red_byte, green_byte, blue_byte, bright_byte  out  8 each  FIFO head = mem_data[7:0], [15:8], [23:16], [31:24].
- underflow  out  1  sticky; set when rd arrives with the FIFO empty.
- frame_start  out  1  one-clk pulse on each flush.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, all byte outputs=0, underflow=0, frame_start=0. FIFO is empty, word counter=0, sync registers=1.
- vsync_n synchronisation: 2-FF synchroniser into clk, plus a third register for edge detection.
- Flush is triggered by the 1->0 edge of synchronised vsync_n (3-4 clk after the pin edge). In the flush cycle:
  - FIFO pointers and count are cleared.
  - mem_addr and the next-fetch address are loaded from base_addr.
  - word counter=0, underflow cleared, frame_start=1 for exactly one clk.
- Fetch FSM states:
  - IDLE -> REQ when fetch_enable=1, word counter < words_per_frame, and count < 2^fifo_depth_log2. On entry, mem_req=1 and mem_addr=next address.
  - REQ: hold mem_req and mem_addr stable. On mem_ack, push mem_data (unless discard is set), increment address and word counter, drop mem_req, return to IDLE.
  - Minimum one idle cycle between requests: mem_req is low for at least one clk after each ack.
- Flush while in REQ:
  - mem_req stays asserted until ack, so the bus transaction is never abandoned.
  - The discard flag is set; the acked word is not pushed and the counter/address do not advance.
  - The next request uses base_addr.
- Flush and mem_ack in the same cycle: the acked data is discarded.
- Flush and rd in the same cycle: flush wins, no pop.
- FIFO storage:
  - Circular buffer with fifo_depth_log2-bit pointers wrapping naturally, plus a (fifo_depth_log2+1)-bit count.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A push while full cannot occur, since the FSM gates on count. Any such push is a verification error.
- Outputs:
  - Byte outputs are the registered head word, updated one clk after a pop or after a push into an empty FIFO.
  - When empty, the outputs hold 0 (black).
- rd while empty: no pointer change, underflow set to 1; it stays 1 until the next flush or reset.
- End of frame: after words_per_frame acks, no further requests until the next flush. The FIFO still drains normally.
- Reset mid-transaction: mem_req drops immediately (async). The memory side must tolerate an abandoned request.
- fetch_enable=0 while in REQ: the current request completes; no new one is issued.

Test Plan:
- Reset, fetch_enable=1, mem_ack 2 clk after each req, no rd -> exactly 16 requests at addresses base, base+1 … base+15; then mem_req stays 0 with count=16.
- After fill, one rd pulse -> outputs change from word 0 to word 1 one clk later; a new request for base+16 follows.
- Word 0x80FF00AA at the FIFO head -> bright_byte=0x80, blue_byte=0xFF, green_byte=0x00, red_byte=0xAA.
- vsync_n falls while mem_req is pending, with ack 5 clk later -> frame_start pulses once; the acked word is discarded; the next mem_addr is base_addr; count=0 and outputs=0 until the next push.
- Set words_per_frame=20, then pop continuously -> exactly 20 acks, then no requests until a vsync_n falling edge restarts fetching at base.
- rd with the FIFO empty (mem_ack held low) -> underflow=1 and remains 1 through later pushes; cleared at the next flush.

Source files
------------

// File: rtl/vga_fifo_fetch.sv
// vga_fifo_fetch: fetches pixel words from RAM into a small FIFO for the
// VGA stage; a falling vsync_n flushes the FIFO and restarts the frame.
module vga_fifo_fetch #(
  parameter int addr_width      = 30,
  parameter int fifo_depth_log2 = 4,
  parameter int words_per_frame = 38400
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [addr_width-1:0] base_addr,
  input  logic                  fetch_enable,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  input  logic                  rd,
  input  logic                  vsync_n,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underflow,
  output logic                  frame_start
);

  localparam int depth = 1 << fifo_depth_log2;
  localparam int cnt_w = $clog2(words_per_frame + 1);
  localparam logic [cnt_w-1:0] frame_words = cnt_w'(words_per_frame);
  localparam logic [fifo_depth_log2:0] full_cnt =
    {1'b1, {fifo_depth_log2{1'b0}}};
  localparam logic [fifo_depth_log2:0] one_cnt =
    {{fifo_depth_log2{1'b0}}, 1'b1};

  typedef logic [fifo_depth_log2-1:0] ptr_t;
  typedef enum logic {IDLE, REQ} state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [2:0]               vs_sync;
  logic                     flush;
  logic [addr_width-1:0]    next_addr;
  logic [cnt_w-1:0]         word_cnt;
  logic                     discard;
  logic [31:0]              fifo_mem [depth];
  ptr_t                     wr_ptr;
  ptr_t                     rd_ptr;
  ptr_t                     rd_nx;
  logic [fifo_depth_log2:0] count;
  logic [31:0]              head;
  logic [31:0]              head_nx;
  logic                     start;
  logic                     ack_ok;
  logic                     push;
  logic                     pop;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) vs_sync <= 3'b111;
    else          vs_sync <= {vs_sync[1:0], vsync_n};

  assign flush   = vs_sync[2] & ~vs_sync[1];
  assign mem_req = (state == REQ);
  assign ack_ok  = (state == REQ) && mem_ack;
  assign push    = ack_ok && !discard && !flush;
  assign pop     = rd && (count != '0) && !flush;
  assign rd_nx   = rd_ptr + 1'b1;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE:
        if (!flush && fetch_enable && word_cnt < frame_words
            && count < full_cnt) begin
          state_nx = REQ;
          start    = 1'b1;
        end
      REQ:
        if (mem_ack) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // A flush never abandons a bus cycle: the pending word is just discarded.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      mem_addr    <= '0;
      next_addr   <= '0;
      word_cnt    <= '0;
      discard     <= 1'b0;
      underflow   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_start <= flush;
      if (start) mem_addr <= next_addr;
      if (flush) begin
        next_addr <= base_addr;
        word_cnt  <= '0;
        underflow <= 1'b0;
        discard   <= (state == REQ) && !mem_ack;
        if (state != REQ || mem_ack) mem_addr <= base_addr;
      end else begin
        if (push) begin
          next_addr <= next_addr + 1'b1;
          word_cnt  <= word_cnt + 1'b1;
        end
        if (ack_ok) discard <= 1'b0;
        if (rd && count == '0) underflow <= 1'b1;
      end
    end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= mem_data;

  // Head register tracks the word that will be at the front after this edge.
  always_comb begin
    head_nx = head;
    if (pop) begin
      if (count > one_cnt) head_nx = fifo_mem[rd_nx];
      else if (push)       head_nx = mem_data;
      else                 head_nx = '0;
    end else if (push && count == '0) begin
      head_nx = mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      head <= head_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nx;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end

  assign red_byte    = head[7:0];
  assign green_byte  = head[15:8];
  assign blue_byte   = head[23:16];
  assign bright_byte = head[31:24];

endmodule

// File: tb/tb_vga_fifo_fetch.sv
// Bench for vga_fifo_fetch: queue-based reference model, random RAM
// contents and a randomised memory responder.
module tb_vga_fifo_fetch;
  localparam int aw  = 30;
  localparam int wpf = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [aw-1:0] base_addr = '0;
  logic          fetch_enable = 1'b0;
  logic [aw-1:0] mem_addr;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_data = '0;
  logic          rd = 1'b0;
  logic          vsync_n = 1'b1;
  logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
  logic          underflow;
  logic          frame_start;
  logic [31:0]   head_out;

  always #5 clk = ~clk;

  vga_fifo_fetch #(
    .addr_width(aw), .fifo_depth_log2(4), .words_per_frame(wpf)
  ) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .fetch_enable(fetch_enable), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data), .rd(rd), .vsync_n(vsync_n),
    .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
    .bright_byte(bright_byte), .underflow(underflow),
    .frame_start(frame_start)
  );

  assign head_out = {bright_byte, blue_byte, green_byte, red_byte};

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   ram [bit [aw-1:0]];
  logic [31:0]   q [$];
  logic [aw-1:0] req_log [$];
  bit            uf, stale, resp_en, req_prev;
  int            words, lat_cnt, ack_lat, flush_cd, acks, fs_cnt;
  logic [aw-1:0] exp_addr, addr_prev;
  int head_err, uf_err, fs_err, addr_err, gate_err, gap_err, stab_err;

  function automatic logic [31:0] word_at(input logic [aw-1:0] a);
    if (!ram.exists(a)) ram[a] = $urandom;
    return ram[a];
  endfunction

  task automatic model_reset();
    q.delete();
    uf = 0; stale = 0; words = 0; exp_addr = '0;
    lat_cnt = 0; flush_cd = 0; req_prev = 0;
  endtask

  // One clock: drive at negedge, advance the model, observe at next negedge.
  task automatic cyc(input bit rd_i);
    bit ack, fl;
    logic [31:0] d, hexp;
    rd = rd_i;
    ack = 0;
    if (mem_req && resp_en) begin
      if (lat_cnt >= ack_lat) begin ack = 1; lat_cnt = 0; end
      else lat_cnt++;
    end else if (!mem_req) lat_cnt = 0;
    d = ack ? word_at(mem_addr) : $urandom;
    mem_ack = ack;
    mem_data = d;
    fl = (flush_cd == 1);
    if (flush_cd > 0) flush_cd--;
    if (fl) begin
      q.delete(); uf = 0; words = 0; exp_addr = base_addr;
      if (mem_req) stale = 1;
    end else begin
      if (rd_i) begin
        if (q.size() == 0) uf = 1;
        else void'(q.pop_front());
      end
      if (ack && !stale) begin q.push_back(d); words++; exp_addr++; end
    end
    if (ack) begin stale = 0; acks++; end
    @(posedge clk);
    @(negedge clk);
    hexp = (q.size() != 0) ? q[0] : 32'h0;
    if (head_out !== hexp) head_err++;
    if (underflow !== uf) uf_err++;
    if (frame_start !== fl) fs_err++;
    if (frame_start) fs_cnt++;
    if (mem_req && !req_prev) begin
      req_log.push_back(mem_addr);
      if (mem_addr !== exp_addr) addr_err++;
      if (q.size() >= 16 || words >= wpf || !fetch_enable) gate_err++;
    end
    if (mem_req && req_prev && mem_addr !== addr_prev) stab_err++;
    if (mem_req && ack) gap_err++;
    req_prev = mem_req;
    addr_prev = mem_addr;
    rd = 0;
    mem_ack = 0;
  endtask

  task automatic do_flush(input logic [aw-1:0] b);
    base_addr = b;
    vsync_n = 0;
    flush_cd = 3;
    repeat (4) cyc(0);
    vsync_n = 1;
    repeat (2) cyc(0);
  endtask

  task automatic drain();
    fetch_enable = 0;
    resp_en = 1;
    for (int i = 0; i < 20 && mem_req; i++) cyc(0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: req %b addr %h want 0 0", mem_req, mem_addr);
    end
    n_cmp++;
    if (head_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_bytes: got %h want 0", head_out);
    end
    n_cmp++;
    if (underflow !== 1'b0 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: uf %b fs %b want 0 0",
               underflow, frame_start);
    end
    reset_n = 1;
    model_reset();
    repeat (3) cyc(0);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: req %b want 0", mem_req);
    end
  endtask

  task automatic test_fill(output logic [aw-1:0] b);
    b = aw'($urandom_range(256, 100000));
    ram[b] = 32'h80FF00AA;
    ack_lat = 1;
    resp_en = 1;
    fs_cnt = 0;
    do_flush(b);
    req_log.delete();
    fetch_enable = 1;
    repeat (120) cyc(0);
    n_cmp++;
    if (req_log.size() != 16) begin
      n_bad++;
      $display("FAIL fill_req_count: got %0d want 16", req_log.size());
    end
    for (int i = 0; i < 16 && i < req_log.size(); i++) begin
      n_cmp++;
      if (req_log[i] !== b + aw'(i)) begin
        n_bad++;
        $display("FAIL fill_addr[%0d]: got %h want %h",
                 i, req_log[i], b + aw'(i));
      end
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_stop: req %b want 0", mem_req);
    end
    n_cmp++;
    if (bright_byte !== 8'h80 || blue_byte !== 8'hFF
        || green_byte !== 8'h00 || red_byte !== 8'hAA) begin
      n_bad++;
      $display("FAIL byte_split: got %h %h %h %h want 80 ff 00 aa",
               bright_byte, blue_byte, green_byte, red_byte);
    end
    n_cmp++;
    if (fs_cnt != 1) begin
      n_bad++;
      $display("FAIL fill_frame_start: got %0d pulses want 1", fs_cnt);
    end
  endtask

  task automatic test_pop_one(input logic [aw-1:0] b);
    logic [31:0] w1;
    w1 = ram[b + 1];
    req_log.delete();
    cyc(1);
    n_cmp++;
    if (head_out !== w1) begin
      n_bad++;
      $display("FAIL pop_head: got %h want %h", head_out, w1);
    end
    repeat (20) cyc(0);
    n_cmp++;
    if (req_log.size() != 1 || req_log[0] !== b + aw'(16)) begin
      n_bad++;
      $display("FAIL refill_addr: n %0d first %h want 1 %h",
               req_log.size(), (req_log.size() != 0) ? req_log[0] : '0,
               b + aw'(16));
    end
  endtask

  task automatic test_flush_pending();
    logic [aw-1:0] b2;
    b2 = aw'($urandom_range(200000, 300000));
    ack_lat = 4;
    cyc(1);
    for (int i = 0; i < 20 && !mem_req; i++) cyc(0);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_req: req %b want 1", mem_req);
    end
    base_addr = b2;
    vsync_n = 0;
    flush_cd = 3;
    fs_cnt = 0;
    repeat (3) cyc(0);
    n_cmp++;
    if (frame_start !== 1'b1 || head_out !== 32'h0 || mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_cycle: fs %b head %h req %b want 1 0 1",
               frame_start, head_out, mem_req);
    end
    vsync_n = 1;
    req_log.delete();
    repeat (30) cyc(0);
    n_cmp++;
    if (req_log.size() == 0 || req_log[0] !== b2) begin
      n_bad++;
      $display("FAIL restart_addr: n %0d first %h want %h", req_log.size(),
               (req_log.size() != 0) ? req_log[0] : '0, b2);
    end
    n_cmp++;
    if (fs_cnt != 1 || head_err != 0) begin
      n_bad++;
      $display("FAIL discard: pulses %0d head_err %0d want 1 0",
               fs_cnt, head_err);
    end
  endtask

  task automatic test_end_of_frame();
    logic [aw-1:0] b3, b4;
    int a0;
    b3 = aw'($urandom_range(400000, 500000));
    b4 = aw'($urandom_range(600000, 700000));
    ack_lat = $urandom_range(0, 2);
    drain();
    do_flush(b3);
    req_log.delete();
    a0 = acks;
    fetch_enable = 1;
    repeat (300) cyc(1);
    n_cmp++;
    if (acks - a0 != wpf || req_log.size() != wpf) begin
      n_bad++;
      $display("FAIL frame_words: acks %0d reqs %0d want %0d",
               acks - a0, req_log.size(), wpf);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_end_idle: req %b want 0", mem_req);
    end
    req_log.delete();
    do_flush(b4);
    repeat (10) cyc(0);
    n_cmp++;
    if (req_log.size() == 0 || req_log[0] !== b4) begin
      n_bad++;
      $display("FAIL next_frame_addr: n %0d first %h want %h", req_log.size(),
               (req_log.size() != 0) ? req_log[0] : '0, b4);
    end
  endtask

  task automatic test_underflow();
    int a0;
    drain();
    resp_en = 0;
    do_flush(aw'($urandom_range(800000, 900000)));
    fetch_enable = 1;
    repeat (5) cyc(0);
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL uf_clear_start: got %b want 0", underflow);
    end
    cyc(1);
    n_cmp++;
    if (underflow !== 1'b1) begin
      n_bad++;
      $display("FAIL uf_set: got %b want 1", underflow);
    end
    a0 = acks;
    resp_en = 1;
    repeat (30) cyc(0);
    n_cmp++;
    if (underflow !== 1'b1 || acks == a0) begin
      n_bad++;
      $display("FAIL uf_sticky: uf %b acks %0d want 1 >0",
               underflow, acks - a0);
    end
    do_flush(aw'($urandom_range(900001, 990000)));
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL uf_flush: got %b want 0", underflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      fetch_enable = ($urandom_range(0, 7) != 0);
      if (!mem_req) ack_lat = $urandom_range(0, 3);
      if (i % 250 == 249) do_flush(aw'($urandom));
      else cyc($urandom_range(0, 2) == 0);
    end
    n_cmp++;
    if (head_err != 0 || uf_err != 0 || fs_err != 0) begin
      n_bad++;
      $display("FAIL model_outputs: head %0d uf %0d fs %0d errors want 0",
               head_err, uf_err, fs_err);
    end
    n_cmp++;
    if (addr_err != 0 || gate_err != 0) begin
      n_bad++;
      $display("FAIL model_requests: addr %0d gate %0d errors want 0",
               addr_err, gate_err);
    end
    n_cmp++;
    if (gap_err != 0 || stab_err != 0) begin
      n_bad++;
      $display("FAIL bus_protocol: gap %0d stable %0d errors want 0",
               gap_err, stab_err);
    end
  endtask

  task automatic test_reset_mid();
    resp_en = 1;
    ack_lat = 3;
    fetch_enable = 1;
    do_flush(aw'($urandom_range(1000, 2000)));
    for (int i = 0; i < 20 && !mem_req; i++) cyc(0);
    reset_n = 0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || head_out !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: req %b addr %h head %h want 0 0 0",
               mem_req, mem_addr, head_out);
    end
    @(negedge clk);
    reset_n = 1;
    fetch_enable = 0;
    model_reset();
    repeat (3) cyc(0);
    n_cmp++;
    if (mem_req !== 1'b0 || underflow !== 1'b0 || head_err != 0) begin
      n_bad++;
      $display("FAIL post_reset: req %b uf %b head_err %0d want 0 0 0",
               mem_req, underflow, head_err);
    end
  endtask

  initial begin
    logic [aw-1:0] b;
    model_reset();
    resp_en = 1;
    ack_lat = 1;
    acks = 0;
    fs_cnt = 0;
    head_err = 0; uf_err = 0; fs_err = 0; addr_err = 0;
    gate_err = 0; gap_err = 0; stab_err = 0;
    test_reset();
    test_fill(b);
    test_pop_one(b);
    test_flush_pending();
    test_end_of_frame();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
